// File: rtl/spmv_rd_arb_pkg.sv
// Shared constants for the SpMV read arbiter: defaults, AR FSM encoding, route entry layout.
package spmv_rd_arb_pkg;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned OUTSTANDING_DEF = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Route entry is {requester index, burst length}; index field sized for up to 8 requesters.
  localparam int unsigned ROUTE_GNT_W = 3;
  localparam int unsigned ROUTE_LEN_W = 8;
  localparam int unsigned ROUTE_W     = ROUTE_GNT_W + ROUTE_LEN_W;

endpackage

// File: rtl/spmv_rd_route_fifo.sv
// Synchronous FIFO of route entries, one per issued AR burst, popped on the burst's last R beat.
module spmv_rd_route_fifo
  import spmv_rd_arb_pkg::*;
#(
  parameter int unsigned DEPTH = OUTSTANDING_DEF,
  parameter int unsigned WIDTH = ROUTE_W,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spmv_rd_arb.sv
// N:1 AXI read arbiter with in-order R routing via a route FIFO.
// Optional SPMV_RD_ARB_PRIO0_EN: requester 0 has absolute priority over round-robin.
module spmv_rd_arb
  import spmv_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned ADDR_WIDTH  = 48,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ-1:0]            s_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]          s_arlen,
  output logic [NUM_REQ-1:0]            s_rvalid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic                          s_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rlast,
  output logic                          err_orphan
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

  logic [0:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       rr_next;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   can_grant;
  int unsigned            cand;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [7:0]             sel_len;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [ROUTE_W-1:0]     route_din;
  logic [ROUTE_W-1:0]     route_head;
  logic [ROUTE_GNT_W-1:0] head_gnt;
  logic [ROUTE_LEN_W-1:0] head_len;
  logic                   r_hs;
  logic [7:0]             beat_cnt;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_any && s_arvalid[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
`ifdef SPMV_RD_ARB_PRIO0_EN
    if (s_arvalid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
  end

  assign can_grant = (state == ST_IDLE) && (fifo_cnt < CNT_W'(OUTSTANDING)) && grant_any;
  assign rr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    s_arready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_addr = s_araddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = s_arlen[k*8 +: 8];
      end
    end
    if (can_grant) begin
      s_arready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
    end else if (state == ST_IDLE) begin
      if (can_grant) begin
        state     <= ST_ISSUE;
        m_arvalid <= 1'b1;
        m_araddr  <= sel_addr;
        m_arlen   <= sel_len;
`ifdef SPMV_RD_ARB_PRIO0_EN
        if (grant_idx != '0) begin
          rr_ptr <= rr_next;
        end
`else
        rr_ptr <= rr_next;
`endif
      end
    end else begin
      if (m_arready) begin
        state     <= ST_IDLE;
        m_arvalid <= 1'b0;
      end
    end
  end

  assign route_din = {ROUTE_GNT_W'(grant_idx), sel_len};
  assign fifo_push = can_grant;
  assign head_gnt  = route_head[ROUTE_W-1 -: ROUTE_GNT_W];
  assign head_len  = route_head[ROUTE_LEN_W-1:0];

  // With nothing outstanding the master R channel is sunk so a stray beat cannot wedge it.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    if (!fifo_empty) begin
      m_rready = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (head_gnt == ROUTE_GNT_W'(k)) begin
          s_rvalid[k] = m_rvalid;
          m_rready    = s_rready[k];
        end
      end
    end
  end

  assign s_rdata  = m_rdata;
  assign s_rlast  = m_rlast;
  assign r_hs     = m_rvalid & m_rready & ~fifo_empty;
  assign fifo_pop = r_hs & m_rlast;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_orphan <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (fifo_empty && m_rvalid) begin
        err_orphan <= 1'b1;
      end
      if (r_hs) begin
        beat_cnt <= m_rlast ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  spmv_rd_route_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ROUTE_W)
  ) u_route_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (route_din),
    .pop   (fifo_pop),
    .dout  (route_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // The last beat of a routed burst must land exactly on its declared length.
  a_burst_len: assert property (@(posedge clk) disable iff (!rstn)
    r_hs |-> (m_rlast == (beat_cnt == head_len)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_spmv_rd_arb.sv
// Scoreboard bench for spmv_rd_arb: stimulus queues expectations, a negedge monitor checks them.
module tb_spmv_rd_arb;

  localparam int NR = 4;
  localparam int AW = 48;
  localparam int DW = 256;
  localparam int OS = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    s_arvalid;
  logic [NR-1:0]    s_arready;
  logic [NR*AW-1:0] s_araddr;
  logic [NR*8-1:0]  s_arlen;
  logic [NR-1:0]    s_rvalid;
  logic [NR-1:0]    s_rready;
  logic [DW-1:0]    s_rdata;
  logic             s_rlast;
  logic             m_arvalid;
  logic             m_arready;
  logic [AW-1:0]    m_araddr;
  logic [7:0]       m_arlen;
  logic             m_rvalid;
  logic             m_rready;
  logic [DW-1:0]    m_rdata;
  logic             m_rlast;
  logic             err_orphan;

  always #5 clk = ~clk;

  spmv_rd_arb #(
    .NUM_REQ     (NR),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .OUTSTANDING (OS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_araddr   (s_araddr),
    .s_arlen    (s_arlen),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .s_rdata    (s_rdata),
    .s_rlast    (s_rlast),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rdata    (m_rdata),
    .m_rlast    (m_rlast),
    .err_orphan (err_orphan)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int k; logic [DW-1:0] data; logic last; } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  gnt_q[$];

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  logic [NR-1:0] hs_pending = '0;
  int  last_gnt_cyc = -10;
  logic prev_av = 1'b0;
  ar_t mon_ar;
  r_t  mon_r;
  int  mon_g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  always @(negedge clk) begin
    hs_pending = s_arvalid & s_arready;
    if (rstn) begin
      if (m_arvalid && !prev_av) chk("arvalid_latency", 64'(cyc), 64'(last_gnt_cyc + 1));
      if (s_arready != '0) begin
        if (gnt_q.size() == 0) fail_now("unexpected_grant");
        else begin
          mon_g = gnt_q.pop_front();
          chk("grant", 64'(s_arready), 64'(1) << mon_g);
        end
        last_gnt_cyc = cyc;
      end
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) fail_now("unexpected_ar");
        else begin
          mon_ar = ar_q.pop_front();
          chk("ar_addr", 64'(m_araddr), 64'(mon_ar.addr));
          chk("ar_len", 64'(m_arlen), 64'(mon_ar.len));
        end
      end
      if (s_rvalid != '0) begin
        chk("rvalid_onehot", 64'($countones(s_rvalid)), 64'd1);
        for (int k = 0; k < NR; k++) begin
          if (s_rvalid[k] && s_rready[k]) begin
            if (r_q.size() == 0) fail_now("unexpected_r");
            else begin
              mon_r = r_q.pop_front();
              chk("r_port", 64'(k), 64'(mon_r.k));
              chk("r_data", s_rdata[63:0], mon_r.data[63:0]);
              chk("r_last", 64'(s_rlast), 64'(mon_r.last));
            end
          end
        end
      end
    end
    prev_av = m_arvalid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s_arvalid = s_arvalid & ~hs_pending;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [7:0] l);
    s_araddr[k*AW +: AW] = a;
    s_arlen[k*8 +: 8]    = l;
  endtask

  task automatic expect_ar(input int k, input logic [AW-1:0] a, input logic [7:0] l);
    gnt_q.push_back(k);
    ar_q.push_back('{addr: a, len: l});
  endtask

  task automatic expect_r(input int k, input logic [DW-1:0] d, input logic last);
    r_q.push_back('{k: k, data: d, last: last});
  endtask

  task automatic wait_granted(input string name);
    for (int i = 0; i < 40 && s_arvalid != '0; i++) tick();
    chk(name, 64'(s_arvalid), 64'd0);
  endtask

  task automatic check_drained(input string name);
    chk({name, "_gnt_left"}, 64'(gnt_q.size()), 64'd0);
    chk({name, "_ar_left"}, 64'(ar_q.size()), 64'd0);
    chk({name, "_r_left"}, 64'(r_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    rstn      = 1'b0;
    s_arvalid = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    s_rready  = '1;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int beat_cyc;
    int grants;
    s_arvalid = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_rready  = '1;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_rdata   = '0;
    apply_reset();

    @(negedge clk);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_araddr", 64'(m_araddr), 64'd0);
    chk("rst_m_arlen", 64'(m_arlen), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);
    chk("rst_m_rready", 64'(m_rready), 64'd1);
    tick();

    // All four requesters at once: round-robin order 0..3, then one beat each in issue order.
    m_arready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      set_req(k, AW'(48'h1000 * (k + 1)), 8'd0);
      expect_ar(k, AW'(48'h1000 * (k + 1)), 8'd0);
    end
    s_arvalid = 4'hF;
    wait_granted("t1_grant_done");
    repeat (3) tick();
    for (int k = 0; k < NR; k++) begin
      m_rvalid = 1'b1;
      m_rlast  = 1'b1;
      m_rdata  = DW'(256'hA0 + k);
      expect_r(k, DW'(256'hA0 + k), 1'b1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    check_drained("t1");

    // Eight outstanding with no R traffic; the ninth waits for the first rlast.
    apply_reset();
    m_arready = 1'b1;
    for (int i = 0; i < OS; i++) begin
      set_req(i % NR, AW'(48'h100 * (i + 1)), 8'd0);
      expect_ar(i % NR, AW'(48'h100 * (i + 1)), 8'd0);
      s_arvalid[i % NR] = 1'b1;
      wait_granted("t2_grant_done");
    end
    repeat (3) tick();
    set_req(0, 48'h900, 8'd0);
    s_arvalid[0] = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("full_valid_held", 64'(s_arvalid), 64'd1);
    chk("full_no_ready", 64'(s_arready), 64'd0);
    chk("full_count", 64'(dut.fifo_cnt), 64'd8);
    tick();
    expect_ar(0, 48'h900, 8'd0);
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rdata  = DW'(256'hB0);
    expect_r(0, DW'(256'hB0), 1'b1);
    beat_cyc = cyc;
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    wait_granted("t2_ninth_granted");
    chk("grant_after_pop", 64'(last_gnt_cyc), 64'(beat_cyc + 1));
    repeat (3) tick();
    check_drained("t2");

    // Requester 2 len=3 then requester 0 len=0; stall requester 2 mid-burst.
    apply_reset();
    m_arready = 1'b1;
    set_req(2, 48'h2200, 8'd3);
    expect_ar(2, 48'h2200, 8'd3);
    s_arvalid = 4'b0100;
    wait_granted("t3_grant2");
    set_req(0, 48'h0100, 8'd0);
    expect_ar(0, 48'h0100, 8'd0);
    s_arvalid = 4'b0001;
    wait_granted("t3_grant0");
    repeat (3) tick();
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = DW'(256'hC0 + b);
      m_rlast  = (b == 3);
      if (b == 1) begin
        s_rready = 4'b1011;
        @(negedge clk);
        chk("stall_m_rready", 64'(m_rready), 64'd0);
        chk("stall_s_rvalid", 64'(s_rvalid), 64'b0100);
        tick();
        s_rready = '1;
      end
      expect_r(2, DW'(256'hC0 + b), (b == 3));
      tick();
    end
    m_rdata = DW'(256'hD0);
    m_rlast = 1'b1;
    expect_r(0, DW'(256'hD0), 1'b1);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    check_drained("t3");

    // Orphan beat with nothing outstanding: sunk and flagged stickily.
    @(negedge clk);
    chk("orphan_pre", 64'(err_orphan), 64'd0);
    tick();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rdata  = DW'(256'hEE);
    @(negedge clk);
    chk("orphan_m_rready", 64'(m_rready), 64'd1);
    chk("orphan_s_rvalid", 64'(s_rvalid), 64'd0);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("orphan_sticky", 64'(err_orphan), 64'd1);
    tick();

    // Reset while stuck in ISSUE with three bursts outstanding.
    apply_reset();
    @(negedge clk);
    chk("t5_orphan_cleared", 64'(err_orphan), 64'd0);
    tick();
    m_arready = 1'b1;
    for (int k = 0; k < 3; k++) set_req(k, AW'(48'h5000 + 48'h100 * k), 8'd0);
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    gnt_q.push_back(2);
    ar_q.push_back('{addr: 48'h5000, len: 8'd0});
    ar_q.push_back('{addr: 48'h5100, len: 8'd0});
    s_arvalid = 4'b0111;
    repeat (4) tick();
    m_arready = 1'b0;
    tick();
    @(negedge clk);
    chk("pre_rst_arvalid", 64'(m_arvalid), 64'd1);
    chk("pre_rst_araddr", 64'(m_araddr), 64'h5200);
    chk("pre_rst_count", 64'(dut.fifo_cnt), 64'd3);
    chk("pre_rst_rr_ptr", 64'(dut.rr_ptr), 64'd3);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("mid_rst_count", 64'(dut.fifo_cnt), 64'd0);
    chk("mid_rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("mid_rst_araddr", 64'(m_araddr), 64'd0);
    tick();
    check_drained("t5");

`ifdef SPMV_RD_ARB_PRIO0_EN
    // Requesters 0 and 1 both continuously valid: only requester 0 is ever granted.
    apply_reset();
    m_arready = 1'b1;
    set_req(0, 48'h6000, 8'd0);
    set_req(1, 48'h6100, 8'd0);
    expect_ar(0, 48'h6000, 8'd0);
    s_arvalid = 4'b0011;
    grants = 0;
    for (int n = 0; n < 60 && grants < 4; n++) begin
      tick();
      if (!s_arvalid[0]) begin
        grants++;
        if (grants < 4) begin
          expect_ar(0, 48'h6000, 8'd0);
          s_arvalid[0] = 1'b1;
        end
      end
    end
    chk("prio_grants", 64'(grants), 64'd4);
    s_arvalid = '0;
    repeat (3) tick();
    check_drained("prio");
`else
    grants = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spmv_rd_arb.md
SPMV_RD_ARB -- requirements
Module: spmv_rd_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 48, AXI address width.
REQ-003 SHALL provide parameter DATA_WIDTH, default 256, AXI read data width.
REQ-004 SHALL provide parameter OUTSTANDING, default 8, maximum accepted-but-incomplete bursts (power of 2).
REQ-005 SHALL have these ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- s_arvalid  in  NUM_REQ  per-requester AR valid
- s_arready  out  NUM_REQ  per-requester AR ready
- s_araddr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- s_arlen  in  NUM_REQ*8  packed burst lengths
- s_rvalid  out  NUM_REQ  per-requester R valid
- s_rready  in  NUM_REQ  per-requester R ready
- s_rdata  out  DATA_WIDTH  shared R data, qualified per requester by s_rvalid
- s_rlast  out  1  shared R last
- m_arvalid, m_arready, m_araddr, m_arlen  out/in/out/out  1/1/ADDR_WIDTH/8  master AR channel
- m_rvalid, m_rready, m_rdata, m_rlast  in/out/in/in  1/1/DATA_WIDTH/1  master R channel
- err_orphan  out  1  sticky: R beat arrived with no outstanding burst

Function
REQ-006 SHALL implement a two-state AR FSM: IDLE and ISSUE.
REQ-007 In IDLE with count<OUTSTANDING and any s_arvalid, SHALL grant one requester round-robin starting at rr_ptr, assert s_arready for that requester only in the same cycle, register its addr/len, push {grant, len} into the route FIFO, and enter ISSUE.
REQ-008 In ISSUE, SHALL hold m_arvalid=1 with stable m_araddr/m_arlen until m_arready; on handshake SHALL return to IDLE. Minimum AR spacing: 2 cycles.
REQ-009 rr_ptr SHALL become (grant+1) mod NUM_REQ at each grant.
REQ-010 With count==OUTSTANDING, SHALL assert no s_arready and stay in IDLE.
REQ-011 R routing SHALL use the route FIFO head: s_rvalid[head]=m_rvalid, other bits 0; m_rready=s_rready[head]; s_rdata/s_rlast pass through combinationally with zero latency.
REQ-012 SHALL pop the FIFO on m_rvalid & m_rready & m_rlast.
REQ-013 With the FIFO empty, SHALL drive m_rready=1 and discard beats, setting err_orphan=1 until reset.
REQ-014 Simultaneous push and pop SHALL leave count unchanged; count width SHALL be clog2(OUTSTANDING)+1.
REQ-015 Bursts SHALL complete in AR-issue order; m_arid is not driven (single ID).

Reset
REQ-016 On rstn=0 at a clk edge: FSM=IDLE, rr_ptr=0, count=0, FIFO emptied, err_orphan=0, m_arvalid=0, m_araddr=0, m_arlen=0.
REQ-017 Reset mid-burst SHALL abandon outstanding bursts; downstream is reset together.

Configuration
REQ-018 Macro SPMV_RD_ARB_PRIO0_EN defined: requester 0 SHALL win whenever s_arvalid[0]=1, and rr_ptr SHALL not update on a requester 0 grant; undefined: pure round-robin per REQ-007.

Structure
REQ-019 Package spmv_rd_arb_pkg SHALL hold default NUM_REQ/OUTSTANDING, the FSM state encoding and the route-entry width constant.
REQ-020 Route FIFO SHALL be sub-module spmv_rd_route_fifo (synchronous, registered count, full/empty outputs).

Verification
REQ-021 Bench SHALL cover:
- All 4 requesters assert s_arvalid at once, addresses 0x1000/0x2000/0x3000/0x4000 -> m_araddr order 0x1000,0x2000,0x3000,0x4000; m_arvalid rises 1 cycle after each s_arready pulse.
- 8 grants with m_rvalid held 0 -> 9th request not accepted until the first rlast, then granted the next IDLE cycle.
- Requester 2 bursts len=3 and requester 0 len=0 issued in that order -> 4 beats on s_rvalid[2], then 1 beat on s_rvalid[0]; s_rready[2]=0 stalls m_rready.
- m_rvalid with m_rlast and no outstanding burst -> beat dropped, err_orphan=1 held.
- rstn pulsed in ISSUE with 3 outstanding bursts -> next cycle m_arvalid=0, count=0, rr_ptr=0.
- With SPMV_RD_ARB_PRIO0_EN, requesters 0 and 1 continuously valid -> requester 0 granted every time, requester 1 never.
